// File: rtl/timer_arb_pkg.sv
// Shared types and default sizing for the timer arbiter.
// Imported by the arbiter FSM and its interval counter.
package timer_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/ivl_counter.sv
// Clearable, enable-gated interval counter.
// Clear has priority over enable.
module ivl_counter
    import timer_arb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one shared interval counter.
// All outputs are registered; grant is visible only while counting.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       done,
    output logic [CNT_W-1:0]         count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   win_q, last_q, pick;
    logic [CNT_W-1:0]   len_q, len_pick;
    logic [NUM_REQ-1:0] grant_q, done_q, win_oh;
    logic               busy_q;
    logic               clear, enable;

    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] p;
        logic             f;
        int               k;
        p = last;
        f = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(last) + i) % NUM_REQ;
            if (!f && r[IDX_W'(k)]) begin
                p = IDX_W'(k);
                f = 1'b1;
            end
        end
        return p;
    endfunction

    assign pick     = rr_pick(req, last_q);
    assign len_pick = len[pick*CNT_W +: CNT_W];
    assign win_oh   = NUM_REQ'(1) << win_q;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        enable  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_LOAD;
            end
            S_LOAD: begin
                clear   = 1'b1;
                state_d = req[win_q] ? S_COUNT : S_IDLE;
            end
            S_COUNT: begin
                // Abandon wins over completion on the final cycle
                if (!req[win_q]) begin
                    clear   = 1'b1;
                    state_d = S_IDLE;
                end else if (count == len_q - CNT_W'(1)) begin
                    clear   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    enable = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            len_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && |req) begin
                win_q <= pick;
                len_q <= (len_pick == '0) ? CNT_W'(1) : len_pick;
            end
            if (state_q == S_DONE ||
                ((state_q == S_LOAD || state_q == S_COUNT) && !req[win_q])) begin
                last_q <= win_q;
            end
            grant_q <= (state_d == S_COUNT) ? win_oh : '0;
            done_q  <= (state_d == S_DONE) ? win_oh : '0;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    ivl_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .enable(enable),
        .count (count)
    );

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter with a transaction-level model.
// Directed corner cases followed by randomized traffic.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N*W-1:0] len;
    logic [N-1:0] grant, done;
    logic         busy;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    timer_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .len  (len),
        .grant(grant),
        .busy (busy),
        .done (done),
        .count(count)
    );

    typedef struct {
        int win;
        int cycles;
        bit fin;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   ptr    = N - 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rr(input int mask);
        for (int s = 1; s <= N; s++) begin
            int k;
            k = (ptr + s) % N;
            if (((mask >> k) & 1) != 0) return k;
        end
        return 0;
    endfunction

    function automatic int eff_len(input int w);
        logic [W-1:0] lv;
        lv = len[w*W +: W];
        return (lv == '0) ? 1 : int'(lv);
    endfunction

    task automatic predict(input int mask, input int ab);
        exp_t e;
        e.win    = rr(mask);
        e.fin    = (ab < 0);
        e.cycles = (ab < 0) ? eff_len(e.win) : ab + 1;
        expq.push_back(e);
        ptr = e.win;
    endtask

    // Monitor: grant rise pops an expectation, grant fall settles it
    initial begin
        int cyc;
        logic [N-1:0] prev_g;
        cyc    = 0;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (grant != 0 && prev_g == 0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_grant", int'(grant), 0);
                end else begin
                    cur = expq.pop_front();
                    chk("grant_owner", int'(grant), 1 << cur.win);
                end
                cyc = 0;
            end
            if (grant != 0) begin
                chk("count_step", int'(count), cyc);
                chk("done_during_grant", int'(done), 0);
                chk("busy_with_grant", int'(busy), 1);
                if (prev_g != 0) chk("grant_stable", int'(grant), int'(prev_g));
                cyc++;
            end else begin
                chk("count_idle", int'(count), 0);
                if (prev_g != 0) begin
                    chk("grant_cycles", cyc, cur.cycles);
                    chk("done_pulse", int'(done), cur.fin ? (1 << cur.win) : 0);
                end else begin
                    chk("stray_done", int'(done), 0);
                end
            end
            prev_g = grant;
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_grant();
        int t;
        t = 0;
        while (grant == 0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (grant == 0) chk("grant_timeout", 0, 1);
    endtask

    task automatic txn(input logic [N-1:0] mask, input int ab);
        int t;
        wait_idle();
        req = mask;
        predict(int'(mask), ab);
        wait_grant();
        t = 0;
        if (ab >= 0) begin
            while (count != W'(ab) && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (count != W'(ab)) chk("abandon_timeout", int'(count), ab);
        end else begin
            while (done == 0 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (done == 0) chk("done_timeout", 0, 1);
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t, w, le, ab;
        logic [N-1:0] m;
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness with all requesters held, length 1 each
        for (int i = 0; i < N; i++) len[i*W +: W] = 8'd1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) predict(15, -1);
        n = 0;
        t = 0;
        while (n < 5 && t < 100) begin
            @(negedge clk);
            t++;
            if (done != 0) n++;
        end
        req = '0;
        @(negedge clk);
        chk("fair_dones", n, 5);

        len[0*W +: W] = 8'd3;
        txn(4'b0001, -1);
        len[2*W +: W] = 8'd0;
        txn(4'b0100, -1);
        len[1*W +: W] = 8'd10;
        txn(4'b0010, 4);
        len[0*W +: W] = 8'd2;
        len[1*W +: W] = 8'd2;
        txn(4'b0011, -1);
        len[0*W +: W] = 8'hFF;
        txn(4'b0001, -1);

        repeat (40) begin
            for (int i = 0; i < N; i++) len[i*W +: W] = W'($urandom_range(0, 12));
            m  = N'($urandom_range(1, 15));
            w  = rr(int'(m));
            le = eff_len(w);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, le - 1)) : -1;
            txn(m, ab);
        end

        // Reset in the middle of an interval
        wait_idle();
        len[0*W +: W] = 8'd8;
        req = 4'b0001;
        predict(1, 5);
        wait_grant();
        t = 0;
        while (count != 8'd5 && t < 20) begin
            @(negedge clk);
            t++;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_count", int'(count), 0);
        ptr = N - 1;
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        len[3*W +: W] = 8'd5;
        req = 4'b1000;
        predict(8, -1);
        @(negedge clk);
        chk("post_rst_load", int'(grant), 0);
        @(negedge clk);
        chk("post_rst_grant", int'(grant), 8);
        t = 0;
        while (done == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        req = '0;
        repeat (3) @(negedge clk);

        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the interval counter.
REQ-002 Parameter CNT_W, default 8, interval counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  NUM_REQ  per-requester level request; held high until done or abandoned.
REQ-006 len  input  NUM_REQ*CNT_W  per-requester interval length; requester i in bits [i*CNT_W +: CNT_W].
REQ-007 grant  output  NUM_REQ  one-hot owner of the counter; all-zero when no owner.
REQ-008 busy  output  1  high while state is LOAD, COUNT or DONE.
REQ-009 done  output  NUM_REQ  one-cycle one-hot pulse; interval of requester i completed.
REQ-010 count  output  CNT_W  current counter value; 0 when no grant.

Function
REQ-011 FSM states: IDLE, LOAD, COUNT, DONE; encoding is free.
REQ-012 IDLE: if any req bit high, select winner by round-robin, latch index and len, move to LOAD; else stay.
REQ-013 Round-robin: search starts at (last_winner+1) mod NUM_REQ, wraps, first high req wins; after reset last_winner = NUM_REQ-1, so req[0] has top priority.
REQ-014 Latched length: len value 0 treated as 1; len never re-sampled after IDLE.
REQ-015 LOAD: counter cleared to 0, grant[winner] asserted, move to COUNT; grant visible the cycle after the IDLE sampling edge.
REQ-016 COUNT: counter +1 per cycle; when count == latched_len-1, move to DONE; grant held for exactly latched_len cycles in COUNT.
REQ-017 DONE: grant deasserted, done[winner] high for exactly one cycle, last_winner updated, move to IDLE.
REQ-018 Abandon: req[winner] low in LOAD or COUNT -> next cycle IDLE, grant and count to 0, no done pulse, last_winner still updated.
REQ-019 Requests from non-winners are ignored until IDLE; no preemption.
REQ-020 Back-to-back: a req high in the IDLE cycle after DONE is served; minimum turnaround is 2 cycles from DONE to next grant.
REQ-021 Counter never wraps; max interval 2**CNT_W-1 cycles (len = all ones).
REQ-022 All outputs registered; no combinational path from req or len to any output.

Reset
REQ-023 rst_n low asynchronously forces: state IDLE, grant 0, done 0, busy 0, count 0, last_winner NUM_REQ-1, latched len 0.
REQ-024 Reset asserted mid-interval aborts it without a done pulse; after release the block is in IDLE and samples req at the first posedge.

Structure
REQ-025 Shared package timer_arb_pkg holds the state enum type and defaults for NUM_REQ and CNT_W.
REQ-026 One sub-module ivl_counter (clk, rst_n, clear, enable, count) implements the clearable, enable-gated CNT_W counter; the arbiter FSM drives clear in LOAD and enable in COUNT.
REQ-027 Round-robin selection is a combinational function inside timer_arbiter, not a separate module.

Verification
REQ-028 Single: req=4'b0001, len0=3 -> grant=0001 for 3 cycles with count 0,1,2; done=0001 one cycle; busy low next cycle.
REQ-029 Fairness: req=4'b1111 held, all len=1 -> grants in order 0001,0010,0100,1000,0001; each requester gets a done pulse.
REQ-030 Zero length: req[2] only, len2=0 -> grant=0100 for exactly 1 cycle, count 0, done=0100.
REQ-031 Abandon: req[1] with len1=10, drop req[1] at count=4 -> grant 0 next cycle, no done; then req=4'b0011 -> grant 0001 (pointer past 1).
REQ-032 Reset mid-op: rst_n low at count=5 of len=8 -> all outputs 0 immediately, no done; after release req[3] alone -> grant 1000 two cycles later.
REQ-033 Max length: CNT_W=8, len=8'hFF -> 255 COUNT cycles, count reaches 8'hFE, no wrap, single done.
